// File: rtl/uart_rx_pkg.sv
// Shared constants, state encoding and helpers for the UART receive front-end.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned STATE_W    = 3;

  // State encoding
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } rx_state_t;

  // Legal oversampling ratios
  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Two-out-of-three vote
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling bit timer and majority sampler.
// Ports: CLK/RST clock and async active-low reset; enable keeps the edge
// counter running (held at 0 otherwise); Prescale oversampling ratio P;
// RX_IN synchronized serial line; edge_cnt position inside the current bit;
// sample_bit majority of the three mid-bit samples, valid from P/2+2.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PW = PRESCALE_W
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          enable,
  input  logic [PW-1:0] Prescale,
  input  logic          RX_IN,
  output logic [PW-1:0] edge_cnt,
  output logic          sample_bit
);

  logic [PW-1:0] half;
  logic [PW-1:0] half_m1;
  logic [PW-1:0] half_p1;
  logic [PW-1:0] last;
  logic          s0;
  logic          s1;

  assign half    = Prescale >> 1;
  assign half_m1 = half - PW'(1);
  assign half_p1 = half + PW'(1);
  assign last    = Prescale - PW'(1);

  // Edge counter plus the three mid-bit samples
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      sample_bit <= 1'b0;
    end else if (!enable) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= (edge_cnt == last) ? '0 : edge_cnt + PW'(1);
      if (edge_cnt == half_m1) s0 <= RX_IN;
      if (edge_cnt == half)    s1 <= RX_IN;
      if (edge_cnt == half_p1) sample_bit <= majority3(s0, s1, RX_IN);
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserializing,
// start/stop checks and per-frame status around an external parity checker.
// Ports: CLK/RST clock and async active-low reset; RX_IN serial line (idle
// high); PAR_EN parity bit present; Prescale oversampling ratio; par_err
// parity checker result; P_DATA received byte; sample_bit voted bit value;
// par_chk_en parity checker enable (combinational); data_valid, frm_par_err,
// stp_err, strt_glitch one-cycle status pulses; busy frame in progress.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
  parameter int unsigned PRESCALE_W = uart_rx_pkg::PRESCALE_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  par_err,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  sample_bit,
  output logic                  par_chk_en,
  output logic                  data_valid,
  output logic                  frm_par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  busy
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);

  rx_state_t               state, state_nx;
  logic                    par_en_sh;
  logic [PRESCALE_W-1:0]   presc_sh;
  logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic [DATA_WIDTH-1:0]   p_data_nx;
  logic                    par_err_flag, par_err_flag_nx;
  logic                    load_shadow;
  logic                    data_valid_nx, frm_par_err_nx, stp_err_nx, strt_glitch_nx;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic                    bit_end;
  logic                    stop_eval;

  // Counter runs whenever the next state is not IDLE, so it loads 1 on start detection
  uart_rx_sampler #(
    .PW (PRESCALE_W)
  ) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (state_nx != S_IDLE),
    .Prescale   (presc_sh),
    .RX_IN      (RX_IN),
    .edge_cnt   (edge_cnt),
    .sample_bit (sample_bit)
  );

  assign bit_end   = (edge_cnt == presc_sh - PRESCALE_W'(1));
  // Stop bit is judged early so a back-to-back start edge is not missed
  assign stop_eval = (edge_cnt == (presc_sh >> 1) + PRESCALE_W'(2));

  // Next-state and next-output logic
  always_comb begin
    state_nx        = state;
    bit_cnt_nx      = bit_cnt;
    p_data_nx       = P_DATA;
    par_err_flag_nx = par_err_flag;
    load_shadow     = 1'b0;
    par_chk_en      = 1'b0;
    data_valid_nx   = 1'b0;
    frm_par_err_nx  = 1'b0;
    stp_err_nx      = 1'b0;
    strt_glitch_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!RX_IN) begin
          state_nx        = S_START;
          load_shadow     = 1'b1;
          par_err_flag_nx = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          if (sample_bit) begin
            strt_glitch_nx = 1'b1;
            state_nx       = S_IDLE;
          end else begin
            bit_cnt_nx = '0;
            state_nx   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          p_data_nx[bit_cnt] = sample_bit;
          if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            state_nx = par_en_sh ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_nx = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          par_chk_en      = 1'b1;
          par_err_flag_nx = par_err;
          state_nx        = S_STOP;
        end
      end
      S_STOP: begin
        if (stop_eval) begin
          state_nx       = S_IDLE;
          data_valid_nx  = sample_bit & ~par_err_flag;
          stp_err_nx     = ~sample_bit;
          frm_par_err_nx = par_err_flag;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_IDLE;
      par_en_sh    <= 1'b0;
      presc_sh     <= '0;
      bit_cnt      <= '0;
      P_DATA       <= '0;
      par_err_flag <= 1'b0;
      data_valid   <= 1'b0;
      frm_par_err  <= 1'b0;
      stp_err      <= 1'b0;
      strt_glitch  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      bit_cnt      <= bit_cnt_nx;
      P_DATA       <= p_data_nx;
      par_err_flag <= par_err_flag_nx;
      data_valid   <= data_valid_nx;
      frm_par_err  <= frm_par_err_nx;
      stp_err      <= stp_err_nx;
      strt_glitch  <= strt_glitch_nx;
      busy         <= (state_nx != S_IDLE);
      if (load_shadow) begin
        par_en_sh <= PAR_EN;
        presc_sh  <= Prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with an even-parity checker model.
module tb_uart_rx_frame_ctrl;
  import uart_rx_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic       par_err;
  logic [7:0] p_data;
  logic       sample_bit;
  logic       par_chk_en;
  logic       data_valid;
  logic       frm_par_err;
  logic       stp_err;
  logic       strt_glitch;
  logic       busy;

  uart_rx_frame_ctrl dut (
    .CLK         (clk),
    .RST         (rst_n),
    .RX_IN       (rx_in),
    .PAR_EN      (par_en),
    .Prescale    (prescale),
    .par_err     (par_err),
    .P_DATA      (p_data),
    .sample_bit  (sample_bit),
    .par_chk_en  (par_chk_en),
    .data_valid  (data_valid),
    .frm_par_err (frm_par_err),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch),
    .busy        (busy)
  );

  // Even-parity checker the block is paired with
  assign par_err = par_chk_en & ((^p_data) ^ sample_bit);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Running pulse tallies, sampled on the falling edge
  int unsigned n_dv = 0, n_fpe = 0, n_se = 0, n_sg = 0, n_pce = 0;
  int unsigned dv_cyc = 0, sg_cyc = 0;
  always @(negedge clk) begin
    if (data_valid)  begin n_dv++; dv_cyc = cyc; end
    if (frm_par_err) n_fpe++;
    if (stp_err)     n_se++;
    if (strt_glitch) begin n_sg++; sg_cyc = cyc; end
    if (par_chk_en)  n_pce++;
  end

  int unsigned n_vec = 0, n_miss = 0;
  int unsigned b_dv, b_fpe, b_se, b_sg, b_pce;
  int unsigned k0, k1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_dv = n_dv; b_fpe = n_fpe; b_se = n_se; b_sg = n_sg; b_pce = n_pce;
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = v;
    end
  endtask

  // Drives one frame; the mode inputs are scrambled mid-frame to prove they are shadowed
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pb,
                            input logic stop, input int gbit, output int unsigned start_cyc);
    logic [10:0] seq;
    int          nb;
    seq       = '0;
    seq[8:1]  = d;
    start_cyc = 0;
    if (pe) begin
      seq[9]  = pb;
      seq[10] = stop;
      nb      = 11;
    end else begin
      seq[9] = stop;
      nb     = 10;
    end
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) begin
          prescale  = 6'(p);
          par_en    = pe;
          start_cyc = cyc;
        end else if (i == 0 && c == 1) begin
          prescale = (p == 8) ? 6'd16 : 6'd8;
          par_en   = ~pe;
        end else if (i == nb - 1 && c == 0) begin
          prescale = 6'(p);
          par_en   = pe;
        end
        rx_in = seq[i] ^ ((i == gbit + 1) && (c == p / 2));
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_in    = 1'b1;
    par_en   = 1'b0;
    prescale = 6'(PRESCALE_8);
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({p_data, sample_bit, par_chk_en, data_valid, frm_par_err,
                               stp_err, strt_glitch, busy}), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 5);
    check("idle_busy", 32'(busy), 32'h0);

    // P=8, no parity, 0xA5
    snap();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -10, k0);
    drive(1'b1, 4);
    check("a5_data", 32'(p_data), 32'hA5);
    check("a5_dv_count", n_dv - b_dv, 1);
    check("a5_errors", (n_fpe - b_fpe) + (n_se - b_se) + (n_sg - b_sg), 0);
    check("a5_dv_time", dv_cyc - k0, 79);
    check("a5_busy", 32'(busy), 32'h0);

    // P=16, parity 0 for 0x3C (even count of ones)
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -10, k0);
    drive(1'b1, 4);
    check("3c_pce_count", n_pce - b_pce, 1);
    check("3c_dv_count", n_dv - b_dv, 1);
    check("3c_fpe_count", n_fpe - b_fpe, 0);
    check("3c_dv_time", dv_cyc - k0, 171);
    check("3c_data", 32'(p_data), 32'h3C);

    // Same byte with a wrong parity bit
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -10, k0);
    drive(1'b1, 4);
    check("3cbad_pce_count", n_pce - b_pce, 1);
    check("3cbad_fpe_count", n_fpe - b_fpe, 1);
    check("3cbad_dv_count", n_dv - b_dv, 0);
    check("3cbad_se_count", n_se - b_se, 0);
    check("3cbad_data", 32'(p_data), 32'h3C);

    // Two-cycle low pulse is a false start
    snap();
    prescale = 6'(PRESCALE_8);
    par_en   = 1'b0;
    @(negedge clk);
    rx_in = 1'b0;
    k0    = cyc;
    drive(1'b0, 1);
    drive(1'b1, 12);
    check("glitch_count", n_sg - b_sg, 1);
    check("glitch_time", sg_cyc - k0, 8);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_data", 32'(p_data), 32'h3C);
    check("glitch_dv_count", n_dv - b_dv, 0);

    // P=32, bad stop bit; the still-low line then reads as a false start
    snap();
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, -10, k0);
    drive(1'b1, 48);
    check("81_se_count", n_se - b_se, 1);
    check("81_dv_count", n_dv - b_dv, 0);
    check("81_fpe_count", n_fpe - b_fpe, 0);
    check("81_false_start", n_sg - b_sg, 1);
    check("81_data", 32'(p_data), 32'h81);
    snap();
    send_frame(8'h7E, 32, 1'b0, 1'b0, 1'b1, -10, k0);
    drive(1'b1, 4);
    check("7e_dv_count", n_dv - b_dv, 1);
    check("7e_data", 32'(p_data), 32'h7E);
    check("7e_errors", (n_fpe - b_fpe) + (n_se - b_se) + (n_sg - b_sg), 0);

    // Back-to-back frames, first with a one-cycle glitch mid data bit 2
    snap();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 2, k0);
    check("b2b_first_data", 32'(p_data), 32'h55);
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, -10, k1);
    drive(1'b1, 4);
    check("b2b_dv_count", n_dv - b_dv, 2);
    check("b2b_errors", (n_fpe - b_fpe) + (n_se - b_se) + (n_sg - b_sg), 0);
    check("b2b_second_data", 32'(p_data), 32'hAA);
    check("b2b_dv_time", dv_cyc - k1, 79);
    check("b2b_gap", k1 - k0, 80);

    // Reset in the middle of DATA
    prescale = 6'(PRESCALE_8);
    par_en   = 1'b0;
    drive(1'b0, 8);
    drive(1'b1, 20);
    check("mid_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 32'({p_data, sample_bit, par_chk_en, data_valid, frm_par_err,
                                   stp_err, strt_glitch, busy}), 32'h0);
    drive(1'b1, 3);
    rst_n = 1'b1;
    drive(1'b1, 5);
    check("post_reset_busy", 32'(busy), 32'h0);

    // Normal frame after reset
    snap();
    send_frame(8'h0F, 16, 1'b0, 1'b0, 1'b1, -10, k0);
    drive(1'b1, 4);
    check("0f_dv_count", n_dv - b_dv, 1);
    check("0f_data", 32'(p_data), 32'h0F);
    check("0f_dv_time", dv_cyc - k0, 155);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
